// File: rtl/mux8_rr_scheduler.sv
// Round-robin burst scheduler for a shared 8:1 mux: drives the registered select,
// one-hot grant and valid flag. Each grant is held for up to MAX_BURST cycles.
module mux8_rr_scheduler #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic             en,
  output logic [2:0]       sel,
  output logic [7:0]       gnt,
  output logic             sel_valid,
  output logic             burst_last,
  output logic             o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_cnt,
  output logic [2:0]       o_dbg_ptr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [7:0]       r_gnt;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_ptr;

  logic [2:0]       w_base;
  logic [2:0]       w_win;
  logic             w_found;
  logic             w_cnt_max;
  logic             w_release;

  // Round-robin scan: first set request starting at base, wrapping 7->0.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    logic [3:0] res;
    found = 1'b0;
    res   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        res   = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign w_cnt_max = (r_cnt == CNT_W'(MAX_BURST));
  assign w_release = (r_state == ST_HOLD) && (!req[r_sel] || w_cnt_max);

  // On release the pointer moves past the releasing source in the same cycle,
  // so the arbiter scans from sel+1 instead of the stored pointer.
  assign w_base = (r_state == ST_HOLD) ? (r_sel + 3'd1) : r_ptr;

  always_comb begin
    logic [3:0] w_pick;
    w_pick  = rr_pick(req, w_base);
    w_found = w_pick[3];
    w_win   = w_pick[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_gnt   <= 8'd0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_found) begin
            r_state <= ST_HOLD;
            r_sel   <= w_win;
            r_gnt   <= 8'd1 << w_win;
            r_valid <= 1'b1;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_release) begin
            r_ptr <= r_sel + 3'd1;
            if (en && w_found) begin
              r_sel   <= w_win;
              r_gnt   <= 8'd1 << w_win;
              r_valid <= 1'b1;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 8'd0;
              r_valid <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 8'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign gnt         = r_gnt;
  assign sel_valid   = r_valid;
  assign burst_last  = r_valid && w_cnt_max;
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;
  assign o_dbg_ptr   = r_ptr;

endmodule
